// File: rtl/useq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : useq_pkg
// Purpose  : Shared types and microword field positions for the useq
//            microcode sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package useq_pkg;

  // Width of the fixed low part of a microword (strobes + seqop + pol)
  localparam int BASE_W = 32;

  // Fixed microword field positions
  localparam int REG_LSB = 0;
  localparam int REG_MSB = 23;
  localparam int EXB_LSB = 24;
  localparam int EXB_MSB = 27;
  localparam int SEQ_LSB = 28;
  localparam int SEQ_MSB = 30;
  localparam int POL_BIT = 31;

  // Sequencing operations carried in microword bits [30:28]
  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_JCC      = 3'd2,
    SEQ_CALL     = 3'd3,
    SEQ_RET      = 3'd4,
    SEQ_DISPATCH = 3'd5,
    SEQ_RSVD     = 3'd6,
    SEQ_HALT     = 3'd7
  } seqop_e;

  // Full microword width for a given flag-vector and address width
  function automatic int uword_width(input int flagw, input int uaw);
    return BASE_W + $clog2(flagw) + uaw;
  endfunction

endpackage : useq_pkg
`default_nettype wire

// File: rtl/useq_if.sv
`default_nettype none
// ============================================================================
// Module   : useq_if
// Purpose  : Bus bundle between the sequencer and its surroundings (opcode
//            bus, flags, interrupt, hold, microcode ROM, control strobes).
//            master = sequencer side, slave = system/ROM side.
//            opcode is the latched dispatch opcode, exposed for observation.
// Revision : 1.0 - initial release
// ============================================================================
interface useq_if #(
  parameter int OPW   = 8,
  parameter int UAW   = 10,
  parameter int FLAGW = 8
);
  import useq_pkg::*;

  localparam int UWW = uword_width(FLAGW, UAW);

  logic [OPW-1:0]   dataIn;
  logic [FLAGW-1:0] flagIn;
  logic             nIRQ;
  logic             Hold;
  logic [UWW-1:0]   uromData;
  logic [UAW-1:0]   uromAddr;
  logic [23:0]      regCtrl;
  logic [3:0]       exbusCtrl;
  logic             fetchOut;
  logic             IRQH;
  logic             stkErr;
  logic [OPW-1:0]   opcode;

  modport master (
    input  dataIn, flagIn, nIRQ, Hold, uromData,
    output uromAddr, regCtrl, exbusCtrl, fetchOut, IRQH, stkErr, opcode
  );

  modport slave (
    output dataIn, flagIn, nIRQ, Hold, uromData,
    input  uromAddr, regCtrl, exbusCtrl, fetchOut, IRQH, stkErr, opcode
  );

endinterface : useq_if
`default_nettype wire

// File: rtl/useq_stack.sv
`default_nettype none
// ============================================================================
// Module   : useq_stack
// Purpose  : Circular micro-return stack. A push onto a full stack
//            overwrites the oldest entry; a pop from an empty stack is
//            ignored. Both faults set the sticky err flag until reset.
// Revision : 1.0 - initial release
// ============================================================================
module useq_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int UAW         = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [UAW-1:0] din,
  output logic [UAW-1:0] dout,
  output logic           empty,
  output logic           err
);

  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(STACK_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(STACK_DEPTH);

  logic [UAW-1:0] mem [STACK_DEPTH];
  logic [PW-1:0]  ptr;        // next free slot (oldest slot once full)
  logic [PW-1:0]  ptr_inc;
  logic [PW-1:0]  ptr_dec;
  logic [CW-1:0]  count;
  logic           full;

  // Circular pointer neighbours and occupancy flags
  always_comb begin
    ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
    ptr_dec = (ptr == '0) ? PTR_LAST : ptr - PW'(1);
    empty   = (count == '0);
    full    = (count == CNT_FULL);
    dout    = mem[ptr_dec];
  end

  // Entry storage; contents are meaningless while count is zero
  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr] <= din;
    end
  end

  // Pointer, occupancy and sticky fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (push) begin
      ptr <= ptr_inc;
      if (full) begin
        err <= 1'b1;
      end else begin
        count <= count + CW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        err <= 1'b1;
      end else begin
        ptr   <= ptr_dec;
        count <= count - CW'(1);
      end
    end
  end

endmodule : useq_stack
`default_nettype wire

// File: rtl/useq_engine.sv
`default_nettype none
// ============================================================================
// Module   : useq_engine
// Purpose  : Microcode sequencer. Holds the micro-PC, addresses an external
//            combinational microcode ROM, decodes each microword into
//            register/bus strobes and a sequencing operation (next, jump,
//            conditional jump, call/return, opcode dispatch, halt).
// Options  : USEQ_IRQ_EN - builds the nIRQ synchroniser and interrupt entry.
// Revision : 1.0 - initial release
// ============================================================================
module useq_engine
  import useq_pkg::*;
#(
  parameter int             OPW         = 8,
  parameter int             UAW         = 10,
  parameter int             FLAGW       = 8,
  parameter int             STACK_DEPTH = 4,
  parameter logic [OPW-1:0] RESET_OP    = 8'hE0,
  parameter logic [UAW-1:0] IRQ_VEC     = 10'h3F0
) (
  input logic    Q,
  input logic    Reset,
  useq_if.master bus
);

  localparam int CSW   = $clog2(FLAGW);
  localparam int UWW   = uword_width(FLAGW, UAW);
  localparam int SHIFT = UAW - OPW;
  localparam logic [UAW-1:0] RESET_ADDR = UAW'(RESET_OP) << SHIFT;

  logic [UAW-1:0] upc;
  logic [UAW-1:0] upc_next;
  logic [UAW-1:0] upc_inc;
  logic [UAW-1:0] target;
  logic [UAW-1:0] dispatch_addr;
  logic [CSW-1:0] csel;
  logic [UWW-1:0] word;
  logic [OPW-1:0] opcode;
  seqop_e         seqop;
  logic           pol;
  logic           run;
  logic           active;
  logic           load_op;
  logic           push;
  logic           pop;
  logic           irq_take;
  logic [UAW-1:0] stk_dout;
  logic           stk_empty;
  logic           stk_err;

  // Microword field extraction
  always_comb begin
    word          = bus.uromData;
    seqop         = seqop_e'(word[SEQ_MSB:SEQ_LSB]);
    pol           = word[POL_BIT];
    csel          = word[BASE_W +: CSW];
    target        = word[UWW-1 -: UAW];
    upc_inc       = upc + UAW'(1);
    dispatch_addr = UAW'(bus.dataIn) << SHIFT;
    run           = !bus.Hold;
    active        = !bus.Hold && !Reset;
  end

`ifdef USEQ_IRQ_EN
  logic [1:0] irq_sync;
  logic       irq_pend;
  logic       irq_pending;

  // Two-stage synchroniser for the asynchronous active-low request
  always_ff @(posedge Q) begin
    if (Reset) begin
      irq_sync <= 2'b11;
    end else begin
      irq_sync <= {irq_sync[0], bus.nIRQ};
    end
  end

  // Pending latch: set by a synchronised low, cleared when taken
  always_ff @(posedge Q) begin
    if (Reset) begin
      irq_pend <= 1'b0;
    end else if (run) begin
      irq_pend <= irq_take ? 1'b0 : irq_pending;
    end
  end

  // Interrupt redirect happens only at a DISPATCH or HALT microword
  always_comb begin
    irq_pending = irq_pend || !irq_sync[1];
    irq_take    = run && irq_pending &&
                  ((seqop == SEQ_DISPATCH) || (seqop == SEQ_HALT));
    bus.IRQH    = !Reset && irq_pending;
  end
`else
  // Interrupts not built: request line ignored, indicator held low
  always_comb begin
    irq_take = 1'b0;
    bus.IRQH = 1'b0;
  end
`endif

  // Next micro-PC selection and stack requests
  always_comb begin
    upc_next = upc;
    push     = 1'b0;
    pop      = 1'b0;
    load_op  = 1'b0;
    if (run) begin
      case (seqop)
        SEQ_JUMP: upc_next = target;
        SEQ_JCC:  upc_next = (bus.flagIn[csel] == pol) ? target : upc_inc;
        SEQ_CALL: begin
          push     = 1'b1;
          upc_next = target;
        end
        SEQ_RET: begin
          pop      = 1'b1;
          upc_next = stk_empty ? RESET_ADDR : stk_dout;
        end
        SEQ_DISPATCH: begin
          load_op  = 1'b1;
          upc_next = irq_take ? IRQ_VEC : dispatch_addr;
        end
        SEQ_HALT: begin
          if (irq_take) begin
            upc_next = IRQ_VEC;
          end
        end
        default: upc_next = upc_inc;
      endcase
    end
  end

  // Micro-PC and latched opcode
  always_ff @(posedge Q) begin
    if (Reset) begin
      upc    <= RESET_ADDR;
      opcode <= RESET_OP;
    end else begin
      upc <= upc_next;
      if (load_op) begin
        opcode <= bus.dataIn;
      end
    end
  end

  useq_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .UAW         (UAW)
  ) u_stack (
    .clk   (Q),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .din   (upc_inc),
    .dout  (stk_dout),
    .empty (stk_empty),
    .err   (stk_err)
  );

  // Strobes come straight from the ROM word, blanked under Hold and Reset
  always_comb begin
    bus.uromAddr  = upc;
    bus.opcode    = opcode;
    bus.regCtrl   = active ? word[REG_MSB:REG_LSB] : 24'h0;
    bus.exbusCtrl = active ? word[EXB_MSB:EXB_LSB] : 4'h0;
    bus.fetchOut  = active && (seqop == SEQ_DISPATCH);
    bus.stkErr    = !Reset && stk_err;
  end

endmodule : useq_engine
`default_nettype wire

// File: tb/tb_useq_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_useq_engine
// Purpose  : Self-checking bench for useq_engine: directed scenarios followed
//            by randomized ROM contents and inputs, compared against a
//            behavioural sequencer model.
// Options  : USEQ_IRQ_EN - model includes interrupt entry when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_useq_engine;

  localparam int OPW   = 8;
  localparam int UAW   = 10;
  localparam int FLAGW = 8;
  localparam int DEPTH = 4;
  localparam int UWW   = 45;
  localparam int RADDR = 'h380;
  localparam int IVEC  = 'h3F0;

  logic Q = 1'b0;
  logic Reset;

  useq_if #(.OPW(OPW), .UAW(UAW), .FLAGW(FLAGW)) bus ();

  useq_engine #(
    .OPW         (OPW),
    .UAW         (UAW),
    .FLAGW       (FLAGW),
    .STACK_DEPTH (DEPTH),
    .RESET_OP    (8'hE0),
    .IRQ_VEC     (10'h3F0)
  ) dut (
    .Q     (Q),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Q = ~Q;

  logic [UWW-1:0] rom [1024];
  assign bus.uromData = rom[bus.uromAddr];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_upc;
  int m_stk[$];
  bit m_err;
  int m_op;
  bit m_valid = 1'b0;
  bit m_s1 = 1'b1;
  bit m_s2 = 1'b1;
  bit m_pend = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [UWW-1:0] mk(input int seq, input int tgt, input int cs,
                                        input int pl, input int exb, input int rg);
    logic [UWW-1:0] w;
    w        = '0;
    w[23:0]  = rg[23:0];
    w[27:24] = exb[3:0];
    w[30:28] = seq[2:0];
    w[31]    = pl[0];
    w[34:32] = cs[2:0];
    w[44:35] = tgt[9:0];
    return w;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, advance the model
  task automatic cycle(input bit rst, input bit hold, input int din, input int flg, input bit nirq);
    logic [UWW-1:0] w;
    int  seq, tgt, cs, pl;
    bit  pend, take;
    Reset      = rst;
    bus.Hold   = hold;
    bus.dataIn = din[7:0];
    bus.flagIn = flg[7:0];
    bus.nIRQ   = nirq;
    #4;
    w   = m_valid ? rom[m_upc] : '0;
    seq = int'(w[30:28]);
    tgt = int'(w[44:35]);
    cs  = int'(w[34:32]);
    pl  = int'(w[31]);
`ifdef USEQ_IRQ_EN
    pend = m_pend || !m_s2;
`else
    pend = 1'b0;
`endif
    take = !rst && !hold && pend && (seq == 5 || seq == 7);
    if (m_valid) begin
      chk("uaddr",  64'(bus.uromAddr), 64'(m_upc));
      chk("opcode", 64'(bus.opcode),   64'(m_op));
    end
    chk("regctrl", 64'(bus.regCtrl),   (rst || hold) ? 64'd0 : 64'(w[23:0]));
    chk("exbus",   64'(bus.exbusCtrl), (rst || hold) ? 64'd0 : 64'(w[27:24]));
    chk("fetch",   64'(bus.fetchOut),  64'(!rst && !hold && seq == 5));
    chk("stkerr",  64'(bus.stkErr),    64'(!rst && m_err));
    chk("irqh",    64'(bus.IRQH),      64'(!rst && pend));
    if (rst) begin
      m_upc = RADDR;
      m_stk.delete();
      m_err   = 1'b0;
      m_op    = 'hE0;
      m_valid = 1'b1;
      m_s1    = 1'b1;
      m_s2    = 1'b1;
      m_pend  = 1'b0;
    end else begin
      if (!hold) begin
        m_pend = take ? 1'b0 : pend;
        case (seq)
          1: m_upc = tgt;
          2: m_upc = (((flg >> cs) & 1) == pl) ? tgt : (m_upc + 1) % 1024;
          3: begin
            if (m_stk.size() == DEPTH) begin
              void'(m_stk.pop_front());
              m_err = 1'b1;
            end
            m_stk.push_back((m_upc + 1) % 1024);
            m_upc = tgt;
          end
          4: begin
            if (m_stk.size() == 0) begin
              m_err = 1'b1;
              m_upc = RADDR;
            end else begin
              m_upc = m_stk.pop_back();
            end
          end
          5: begin
            m_op  = din & 'hFF;
            m_upc = take ? IVEC : ((din & 'hFF) * 4);
          end
          7: if (take) m_upc = IVEC;
          default: m_upc = (m_upc + 1) % 1024;
        endcase
      end
      m_s2 = m_s1;
      m_s1 = nirq;
    end
    @(posedge Q);
    #1;
  endtask

  initial begin
    // Background ROM: plain NEXT words with varied strobes
    for (int a = 0; a < 1024; a++) rom[a] = mk(0, 0, 0, 0, a % 16, a * 37 + 5);
    rom['h380] = mk(5, 0, 0, 0, 9, 'hABCDE1);
    rom['h048] = mk(2, 'h100, 3, 1, 1, 'h000111);
    rom['h100] = mk(1, 'h048, 0, 0, 2, 'h000222);
    rom['h049] = mk(3, 'h200, 0, 0, 3, 'h000333);
    rom['h200] = mk(3, 'h210, 0, 0, 4, 'h000444);
    rom['h210] = mk(3, 'h220, 0, 0, 5, 'h000555);
    rom['h220] = mk(3, 'h230, 0, 0, 6, 'h000666);
    rom['h230] = mk(3, 'h240, 0, 0, 7, 'h000777);
    rom['h240] = mk(4, 0, 0, 0, 8, 'h000888);
    rom['h231] = mk(4, 0, 0, 0, 8, 'h000999);
    rom['h221] = mk(4, 0, 0, 0, 8, 'h000AAA);
    rom['h211] = mk(4, 0, 0, 0, 8, 'h000BBB);
    rom['h201] = mk(4, 0, 0, 0, 8, 'h000CCC);
    rom['h0C3] = mk(7, 0, 0, 0, 15, 'h5A5A5A);

    // Reset, then dispatch opcode 0x12
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    chk("rst_addr", 64'(bus.uromAddr), 64'h380);
    cycle(0, 0, 'h12, 0, 1);
    chk("disp_addr", 64'(bus.uromAddr), 64'h048);
    chk("disp_op",   64'(bus.opcode),   64'h12);

    // JCC on flag 3, taken then not taken
    cycle(0, 0, 0, 'h08, 1);
    chk("jcc_taken", 64'(bus.uromAddr), 64'h100);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 'hF7, 1);
    chk("jcc_not", 64'(bus.uromAddr), 64'h049);

    // Five nested calls on a four-deep stack
    repeat (5) cycle(0, 0, 0, 0, 1);
    chk("call_addr", 64'(bus.uromAddr), 64'h240);
    chk("stk_ovf",   64'(bus.stkErr),   64'd1);
    repeat (4) cycle(0, 0, 0, 0, 1);
    chk("ret4", 64'(bus.uromAddr), 64'h201);
    cycle(0, 0, 0, 0, 1);
    chk("ret_uf", 64'(bus.uromAddr), 64'h380);

    // Dispatch into a straight-line block, hold in the middle, then halt
    cycle(0, 0, 'h30, 0, 1);
    cycle(0, 0, 0, 0, 1);
    repeat (3) cycle(0, 1, 'h55, 'hFF, 1);
    chk("hold_addr", 64'(bus.uromAddr), 64'h0C1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("halt_addr", 64'(bus.uromAddr), 64'h0C3);
    repeat (2) cycle(0, 0, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 1);
`ifndef USEQ_IRQ_EN
    chk("halt_noirq", 64'(bus.uromAddr), 64'h0C3);
`endif

    // Randomized microcode and inputs
    for (int a = 0; a < 1024; a++) begin
      int s;
      s = int'($urandom_range(0, 7));
      if (s == 7 && $urandom_range(0, 3) != 0) s = 0;
      rom[a] = mk(s, int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom()));
    end
    cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            $urandom_range(0, 9) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_useq_engine
`default_nettype wire
